// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_arbiter_pkg                                                            |
// | Shared widths, FSM state encoding and requester ids for the memory arbiter.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package mem_arbiter_pkg;

  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int BE_W     = 4;
  localparam int STARVE_W = 3;

  localparam logic [BE_W-1:0] BE_FULL = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2
  } arb_state_e;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_D  = 1'b1
  } req_id_e;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_arbiter_if                                                             |
// | Fetch, data and single-port memory handshake signals of the arbiter.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic              if_ready;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [BE_W-1:0]   d_be;
  logic              d_ready;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_be;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter side: serves the core requesters and drives the memory.
  modport slave (
    input  if_req, if_addr, if_flush, d_req, d_we, d_addr, d_wdata, d_be,
    input  mem_ack, mem_rdata,
    output if_ready, if_rdata, d_ready, d_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

  // Environment side: core requesters plus the memory responder.
  modport master (
    output if_req, if_addr, if_flush, d_req, d_we, d_addr, d_wdata, d_be,
    output mem_ack, mem_rdata,
    input  if_ready, if_rdata, d_ready, d_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_arbiter                                                                |
// | Two-requester (fetch/data) arbiter onto one single-port memory, data      |
// | priority with a bounded fetch-starvation counter.                          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  localparam logic [STARVE_W-1:0] STARVE_LIMIT = STARVE_W'(STARVE_MAX);

  arb_state_e          state_q, state_d;
  logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
  logic                drop_q, drop_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [BE_W-1:0]     mem_be_q, mem_be_d;
  logic                if_ready_q, if_ready_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic                d_ready_q, d_ready_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;

  logic if_eligible;
  logic d_eligible;
  logic fetch_wins;
  logic data_wins;

  assign if_eligible = bus.if_req & ~if_ready_q;
  assign d_eligible  = bus.d_req & ~d_ready_q;

  // A raised d_req keeps priority even during its own ready pulse, so a
  // back-to-back data stream only yields to fetch once starvation saturates.
  assign fetch_wins  = if_eligible & (~bus.d_req | (starve_cnt_q == STARVE_LIMIT));
  assign data_wins   = d_eligible & ~fetch_wins;

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    drop_d       = drop_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_be_d     = mem_be_q;
    if_ready_d   = 1'b0;
    if_rdata_d   = if_rdata_q;
    d_ready_d    = 1'b0;
    d_rdata_d    = d_rdata_q;

    case (state_q)
      IDLE: begin
        if (fetch_wins) begin
          state_d      = BUSY_IF;
          starve_cnt_d = '0;
          drop_d       = 1'b0;
          mem_req_d    = 1'b1;
          mem_we_d     = 1'b0;
          mem_addr_d   = bus.if_addr;
          mem_wdata_d  = '0;
          mem_be_d     = BE_FULL;
        end else if (data_wins) begin
          state_d     = BUSY_D;
          mem_req_d   = 1'b1;
          mem_we_d    = bus.d_we;
          mem_addr_d  = bus.d_addr;
          mem_wdata_d = bus.d_wdata;
          mem_be_d    = bus.d_be;
          if (!bus.if_req) begin
            starve_cnt_d = '0;
          end else if (starve_cnt_q < STARVE_LIMIT) begin
            starve_cnt_d = starve_cnt_q + 3'd1;
          end
        end
      end

      BUSY_IF: begin
        if (bus.if_flush) begin
          drop_d = 1'b1;
        end
        if (bus.mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          drop_d    = 1'b0;
          if (!drop_q && !bus.if_flush) begin
            if_ready_d = 1'b1;
            if_rdata_d = bus.mem_rdata;
          end
        end
      end

      BUSY_D: begin
        if (bus.mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          d_ready_d = 1'b1;
          d_rdata_d = bus.mem_rdata;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      drop_q       <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_be_q     <= '0;
      if_ready_q   <= 1'b0;
      if_rdata_q   <= '0;
      d_ready_q    <= 1'b0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      drop_q       <= drop_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_be_q     <= mem_be_d;
      if_ready_q   <= if_ready_d;
      if_rdata_q   <= if_rdata_d;
      d_ready_q    <= d_ready_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.if_ready  = if_ready_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_ready   = d_ready_q;
  assign bus.d_rdata   = d_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_arbiter                                                             |
// | Directed scoreboard bench: memory responder, core handshake and checks.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic clk;
  logic rst;

  mem_arbiter_if bus ();

  mem_arbiter #(.STARVE_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        is_if;
    logic        chk_data;
    logic [31:0] data;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] grant_log[$];
  logic [2:0]  starve_log[$];

  int          n_tests;
  int          n_fail;
  int          mem_wait;
  int          mem_cnt;
  logic        mem_active;
  logic        inject_ack;
  logic        cap_we;
  logic [3:0]  cap_be;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic        mem_req_prev;
  logic [2:0]  prev_starve;
  int          req_hi;
  int          if_pulses;
  int          d_pulses;
  logic        d_hold;

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'hDEADBEEF;
    return (a * 32'h0001_0003) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic is_if, input logic chk_data, input logic [31:0] d);
    exp_t e;
    e.is_if    = is_if;
    e.chk_data = chk_data;
    e.data     = d;
    sb_q.push_back(e);
  endtask

  task automatic check_ready(input logic is_if, input logic [31:0] rdata);
    exp_t e;
    chk("ready_expected", {31'b0, sb_q.size() != 0}, 32'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk("ready_kind", {31'b0, is_if}, {31'b0, e.is_if});
      if (e.chk_data) chk(is_if ? "if_rdata" : "d_rdata", rdata, e.data);
    end
  endtask

  // One clock: sample outputs, run the memory responder and the core handshake.
  task automatic tick();
    @(negedge clk);
    if (bus.if_ready || bus.d_ready)
      chk("ready_exclusive", {31'b0, bus.if_ready & bus.d_ready}, 32'd0);
    if (bus.if_ready) begin if_pulses++; check_ready(1'b1, bus.if_rdata); end
    if (bus.d_ready)  begin d_pulses++;  check_ready(1'b0, bus.d_rdata);  end

    if (rst) begin
      bus.mem_ack = 1'b0;
      mem_active  = 1'b0;
      mem_cnt     = 0;
    end else if (bus.mem_ack) begin
      chk("mem_req_drop", {31'b0, bus.mem_req}, 32'd0);
      bus.mem_ack = 1'b0;
      mem_active  = 1'b0;
    end else if (bus.mem_req) begin
      if (!mem_active) begin
        mem_active = 1'b1;
        mem_cnt    = 0;
        cap_we     = bus.mem_we;
        cap_be     = bus.mem_be;
        cap_addr   = bus.mem_addr;
        cap_wdata  = bus.mem_wdata;
      end
      if (mem_cnt == mem_wait) begin
        if (mem_cnt > 0) begin
          chk("hold_addr", bus.mem_addr, cap_addr);
          chk("hold_wdata", bus.mem_wdata, cap_wdata);
          chk("hold_we_be", {27'b0, bus.mem_we, bus.mem_be}, {27'b0, cap_we, cap_be});
        end
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = mem_model(bus.mem_addr);
      end else begin
        mem_cnt++;
      end
    end else if (inject_ack) begin
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'hBAD0_BAD0;
      inject_ack    = 1'b0;
    end

    if (bus.mem_req && !mem_req_prev) begin
      grant_log.push_back(bus.mem_addr);
      starve_log.push_back(prev_starve);
    end
    if (bus.mem_req) req_hi++;
    mem_req_prev = bus.mem_req;
    prev_starve  = dut.starve_cnt_q;

    if (bus.if_ready && bus.if_req) bus.if_req = 1'b0;
    if (bus.d_ready && bus.d_req && !d_hold) bus.d_req = 1'b0;
  endtask

  task automatic wait_rise(input string tag, input int budget);
    int k;
    k = 0;
    while (!bus.mem_req && k < budget) begin tick(); k++; end
    chk(tag, {31'b0, k < budget}, 32'd1);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k;
    k = 0;
    while ((sb_q.size() != 0 || bus.mem_req || bus.if_req || bus.d_req) && k < budget) begin
      tick();
      k++;
    end
    chk(tag, {31'b0, k < budget}, 32'd1);
  endtask

  initial begin
    n_tests = 0; n_fail = 0; mem_wait = 0; mem_cnt = 0; mem_active = 1'b0;
    inject_ack = 1'b0; cap_we = 1'b0; cap_be = '0; cap_addr = '0; cap_wdata = '0;
    mem_req_prev = 1'b0; prev_starve = '0; req_hi = 0; if_pulses = 0; d_pulses = 0;
    d_hold = 1'b0;
    bus.if_req = 1'b0; bus.if_addr = '0; bus.if_flush = 1'b0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_be = '0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    rst = 1'b1;

    // Reset state
    tick(); tick();
    chk("rst_state", 32'(dut.state_q), 32'(IDLE));
    chk("rst_mem_ctl", {26'b0, bus.mem_req, bus.mem_we, bus.mem_be}, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst_ready", {30'b0, bus.if_ready, bus.d_ready}, 32'd0);
    chk("rst_if_rdata", bus.if_rdata, 32'd0);
    chk("rst_d_rdata", bus.d_rdata, 32'd0);
    chk("rst_starve_drop", {28'b0, dut.starve_cnt_q, dut.drop_q}, 32'd0);
    rst = 1'b0;
    tick();

    // Load with one wait state; a flush during BUSY_D must not matter
    mem_wait = 1; req_hi = 0; d_pulses = 0;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0000_0100; bus.d_be = 4'hF;
    push_exp(1'b0, 1'b1, 32'hDEADBEEF);
    wait_rise("load_grant_timeout", 20);
    bus.if_flush = 1'b1;
    tick();
    bus.if_flush = 1'b0;
    wait_done("load_timeout", 40);
    chk("load_req_cycles", req_hi, 32'd2);
    chk("load_d_pulses", d_pulses, 32'd1);

    // Store with byte enables, two wait states
    mem_wait = 2; d_pulses = 0;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h0000_2040;
    bus.d_wdata = 32'h0000_1234; bus.d_be = 4'b0011;
    push_exp(1'b0, 1'b0, 32'h0);
    wait_rise("store_grant_timeout", 20);
    chk("store_addr", bus.mem_addr, 32'h0000_2040);
    chk("store_wdata", bus.mem_wdata, 32'h0000_1234);
    chk("store_we_be", {27'b0, bus.mem_we, bus.mem_be}, {27'b0, 1'b1, 4'b0011});
    wait_done("store_timeout", 40);
    chk("store_d_pulses", d_pulses, 32'd1);

    // Simultaneous requests: data first, then fetch
    mem_wait = 0; grant_log.delete(); starve_log.delete();
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0000_2080; bus.d_be = 4'hF;
    bus.if_req = 1'b1; bus.if_addr = 32'h0000_1000;
    push_exp(1'b0, 1'b1, mem_model(32'h0000_2080));
    push_exp(1'b1, 1'b1, mem_model(32'h0000_1000));
    wait_done("conflict_timeout", 40);
    chk("conflict_grants", grant_log.size(), 32'd2);
    if (grant_log.size() == 2) begin
      chk("conflict_first", grant_log[0], 32'h0000_2080);
      chk("conflict_second", grant_log[1], 32'h0000_1000);
    end

    // Starvation: continuous data stream, fetch wins after four data grants
    grant_log.delete(); starve_log.delete(); d_pulses = 0;
    d_hold = 1'b1;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0000_2100;
    bus.if_req = 1'b1; bus.if_addr = 32'h0000_1100;
    for (int i = 0; i < 4; i++) push_exp(1'b0, 1'b1, mem_model(32'h0000_2100));
    push_exp(1'b1, 1'b1, mem_model(32'h0000_1100));
    push_exp(1'b0, 1'b1, mem_model(32'h0000_2100));
    begin
      int k;
      k = 0;
      while (grant_log.size() < 6 && k < 100) begin tick(); k++; end
      chk("starve_grants_timeout", {31'b0, k < 100}, 32'd1);
      k = 0;
      while (d_pulses < 5 && k < 100) begin tick(); k++; end
      chk("starve_pulses_timeout", {31'b0, k < 100}, 32'd1);
    end
    bus.d_req = 1'b0; d_hold = 1'b0;
    wait_done("starve_timeout", 40);
    if (grant_log.size() >= 6) begin
      for (int i = 0; i < 6; i++)
        chk("starve_order", grant_log[i], (i == 4) ? 32'h0000_1100 : 32'h0000_2100);
      chk("starve_cnt_first", {29'b0, starve_log[0]}, 32'd0);
      chk("starve_cnt_before_if", {29'b0, starve_log[4]}, 32'd4);
    end

    // Flushed fetch completes silently; the next fetch returns data
    mem_wait = 2; if_pulses = 0;
    bus.if_req = 1'b1; bus.if_addr = 32'h0000_0040;
    wait_rise("flush_grant_timeout", 20);
    bus.if_flush = 1'b1; bus.if_req = 1'b0;
    tick();
    bus.if_flush = 1'b0;
    wait_done("flush_timeout", 40);
    tick(); tick(); tick();
    chk("flush_no_ready", if_pulses, 32'd0);
    chk("flush_rdata_kept", bus.if_rdata, mem_model(32'h0000_1100));
    chk("flush_drop_clear", {31'b0, dut.drop_q}, 32'd0);
    mem_wait = 0;
    bus.if_req = 1'b1; bus.if_addr = 32'h0000_0080;
    push_exp(1'b1, 1'b1, mem_model(32'h0000_0080));
    wait_done("refetch_timeout", 40);
    chk("refetch_pulses", if_pulses, 32'd1);

    // Reset in BUSY_D, then a stale ack in IDLE
    mem_wait = 3; d_pulses = 0;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0000_2200; bus.d_be = 4'hF;
    wait_rise("rstmid_grant_timeout", 20);
    tick();
    rst = 1'b1; bus.d_req = 1'b0;
    tick();
    chk("rstmid_mem_req", {31'b0, bus.mem_req}, 32'd0);
    chk("rstmid_state", 32'(dut.state_q), 32'(IDLE));
    rst = 1'b0;
    inject_ack = 1'b1;
    tick(); tick(); tick(); tick();
    chk("stale_ack_no_ready", d_pulses + if_pulses, 32'd1);
    chk("stale_ack_state", 32'(dut.state_q), 32'(IDLE));
    chk("stale_ack_mem_req", {31'b0, bus.mem_req}, 32'd0);
    chk("sb_drained", sb_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
